// File: rtl/dip_pkg.sv
// Shared types and helpers for the 3x3 window front end.
// Holds the default pixel width, the streamer FSM encoding, window beat
// offsets and a mod-3 adder for circular row-slot arithmetic.
package dip_pkg;

    localparam int PIX_W_DEF = 24;

    typedef enum logic {
        FILL = 1'b0,
        SEND = 1'b1
    } stream_state_e;

    // Beat k of a window -> {row offset k/3, col offset k%3}, 2 bits each.
    function automatic logic [3:0] win_offset(input logic [3:0] k);
        logic [3:0] off;
        case (k)
            4'd0:    off = 4'b00_00;
            4'd1:    off = 4'b00_01;
            4'd2:    off = 4'b00_10;
            4'd3:    off = 4'b01_00;
            4'd4:    off = 4'b01_01;
            4'd5:    off = 4'b01_10;
            4'd6:    off = 4'b10_00;
            4'd7:    off = 4'b10_01;
            4'd8:    off = 4'b10_10;
            default: off = 4'b00_00;
        endcase
        return off;
    endfunction

    // (a + b) mod 3 for operands already in 0..2.
    function automatic logic [1:0] slot_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= 3'd3) begin
            sum = sum - 3'd3;
        end
        return sum[1:0];
    endfunction

endpackage

// File: rtl/row_store.sv
// Three-row circular pixel buffer, slot = image row mod 3.
// Ports: one synchronous write port (slot, col, data), one combinational
// read port (slot, col); the parent registers the read data.
module row_store #(
    parameter int IMG_W = 64,
    parameter int PIX_W = 24,
    parameter int CW    = $clog2(IMG_W)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [1:0]       wr_slot,
    input  logic [CW-1:0]    wr_col,
    input  logic [PIX_W-1:0] wr_data,
    input  logic [1:0]       rd_slot,
    input  logic [CW-1:0]    rd_col,
    output logic [PIX_W-1:0] rd_data
);

    // Pure storage: contents are only read after being written in the
    // current frame, so no reset is needed.
    logic [PIX_W-1:0] mem_q [3][IMG_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_slot][wr_col] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_slot][rd_col];

endmodule

// File: rtl/window_streamer.sv
// Raster pixel stream in, every interior 3x3 neighbourhood out as a 9-beat
// packet (row-major, top-left first, tlast on beat 8).
// Ports: s_axis_* raster input (tuser = start of frame), m_axis_* window
// output, frame_done pulses after the last window of a frame is accepted.
module window_streamer
    import dip_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int PIX_W = PIX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] s_axis_tdata,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tuser,
    output logic             s_axis_tready,
    output logic [PIX_W-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    input  logic             m_axis_tready,
    output logic             frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] LAST_C = CW'(IMG_W - 1);
    localparam logic [RW-1:0] LAST_R = RW'(IMG_H - 1);
    localparam logic [CW-1:0] TWO_C  = CW'(2);
    localparam logic [RW-1:0] TWO_R  = RW'(2);

    stream_state_e    state_q, state_d;
    logic [RW-1:0]    row_q, row_d;
    logic [CW-1:0]    col_q, col_d;
    logic [1:0]       slot_q, slot_d;           // row_q mod 3
    logic [1:0]       base_slot_q, base_slot_d; // slot of the window's top row
    logic [CW-1:0]    base_col_q, base_col_d;
    logic             last_win_q, last_win_d;
    logic [3:0]       beat_q, beat_d;
    logic [PIX_W-1:0] m_tdata_q, m_tdata_d;
    logic             m_tvalid_q, m_tvalid_d;
    logic             m_tlast_q, m_tlast_d;
    logic             frame_done_q, frame_done_d;

    logic             acc;
    logic [RW-1:0]    cur_r;
    logic [CW-1:0]    cur_c;
    logic [1:0]       cur_slot;
    logic [1:0]       rd_slot;
    logic [CW-1:0]    rd_col;
    logic [PIX_W-1:0] rd_data;
    logic [3:0]       off;

    assign s_axis_tready = (state_q == FILL);
    assign acc           = s_axis_tvalid && s_axis_tready;

    // Start-of-frame overrides the counters for the pixel carrying it.
    assign cur_r    = s_axis_tuser ? '0   : row_q;
    assign cur_c    = s_axis_tuser ? '0   : col_q;
    assign cur_slot = s_axis_tuser ? 2'd0 : slot_q;

    row_store #(
        .IMG_W (IMG_W),
        .PIX_W (PIX_W),
        .CW    (CW)
    ) u_row_store (
        .clk     (clk),
        .wr_en   (acc),
        .wr_slot (cur_slot),
        .wr_col  (cur_c),
        .wr_data (s_axis_tdata),
        .rd_slot (rd_slot),
        .rd_col  (rd_col),
        .rd_data (rd_data)
    );

    // Read address: in FILL, prefetch the base pixel of the window that the
    // current input would open (row r-2 lives in slot (r+1) mod 3); in SEND,
    // prefetch the pixel of the next beat.
    always_comb begin
        off     = win_offset(beat_q + 4'd1);
        rd_slot = slot_add(cur_slot, 2'd1);
        rd_col  = cur_c - TWO_C;
        if (state_q == SEND) begin
            rd_slot = slot_add(base_slot_q, off[3:2]);
            rd_col  = base_col_q + CW'(off[1:0]);
        end
    end

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        slot_d       = slot_q;
        base_slot_d  = base_slot_q;
        base_col_d   = base_col_q;
        last_win_d   = last_win_q;
        beat_d       = beat_q;
        m_tdata_d    = m_tdata_q;
        m_tvalid_d   = m_tvalid_q;
        m_tlast_d    = m_tlast_q;
        frame_done_d = 1'b0;

        case (state_q)
            FILL: begin
                if (acc) begin
                    if (cur_c == LAST_C) begin
                        col_d = '0;
                        if (cur_r == LAST_R) begin
                            row_d  = '0;
                            slot_d = 2'd0;
                        end else begin
                            row_d  = cur_r + 1'b1;
                            slot_d = slot_add(cur_slot, 2'd1);
                        end
                    end else begin
                        col_d  = cur_c + 1'b1;
                        row_d  = cur_r;
                        slot_d = cur_slot;
                    end

                    if (cur_r >= TWO_R && cur_c >= TWO_C) begin
                        state_d     = SEND;
                        base_slot_d = slot_add(cur_slot, 2'd1);
                        base_col_d  = cur_c - TWO_C;
                        last_win_d  = (cur_r == LAST_R) && (cur_c == LAST_C);
                        beat_d      = 4'd0;
                        m_tdata_d   = rd_data;
                        m_tvalid_d  = 1'b1;
                        m_tlast_d   = 1'b0;
                    end
                end
            end
            SEND: begin
                if (m_axis_tready) begin
                    if (beat_q == 4'd8) begin
                        state_d      = FILL;
                        m_tvalid_d   = 1'b0;
                        m_tlast_d    = 1'b0;
                        frame_done_d = last_win_q;
                    end else begin
                        beat_d    = beat_q + 4'd1;
                        m_tdata_d = rd_data;
                        m_tlast_d = (beat_q == 4'd7);
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FILL;
            row_q        <= '0;
            col_q        <= '0;
            slot_q       <= 2'd0;
            base_slot_q  <= 2'd0;
            base_col_q   <= '0;
            last_win_q   <= 1'b0;
            beat_q       <= 4'd0;
            m_tdata_q    <= '0;
            m_tvalid_q   <= 1'b0;
            m_tlast_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            slot_q       <= slot_d;
            base_slot_q  <= base_slot_d;
            base_col_q   <= base_col_d;
            last_win_q   <= last_win_d;
            beat_q       <= beat_d;
            m_tdata_q    <= m_tdata_d;
            m_tvalid_q   <= m_tvalid_d;
            m_tlast_q    <= m_tlast_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tlast  = m_tlast_q;
    assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_window_streamer.sv
// Bench for window_streamer on a 4x4 image: scoreboard of expected window
// beats built from an absolute-row image model, monitor pops on handshakes.
// Ports: drives all DUT inputs, observes all outputs.
module tb_window_streamer;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int PW = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [PW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tuser = 1'b0;
    logic          s_axis_tready;
    logic [PW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready = 1'b1;
    logic          frame_done;

    window_streamer #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PW-1:0] d;
        logic          l;
    } beat_t;

    int      errors = 0;
    int      checks = 0;
    beat_t   exp_q[$];
    logic [PW-1:0] mdl [H][W];
    int      mr = 0;
    int      mc = 0;
    int      exp_done = 0;
    int      done_cnt = 0;
    int      rdy_mode = 0;   // 0: always ready, 1: toggle, 2: random
    bit      prev_stall = 1'b0;
    logic [PW-1:0] prev_d;
    logic    prev_l;

    // Downstream ready, changed just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ~m_axis_tready;
            default: m_axis_tready = 1'($urandom_range(0, 1));
        endcase
    end

    // Output monitor: scoreboard pops, AXI hold rule, SEND blocks input,
    // frame_done only after the frame's last beat has gone.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_d || m_axis_tlast !== prev_l) begin
                    errors++;
                    $display("FAIL hold: got v=%b d=%h l=%b, need v=1 d=%h l=%b",
                             m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_d, prev_l);
                end
            end
            if (m_axis_tvalid) begin
                checks++;
                if (s_axis_tready !== 1'b0) begin
                    errors++;
                    $display("FAIL s_ready_in_send: got %b, need 0", s_axis_tready);
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got d=%h l=%b, need no beat", m_axis_tdata, m_axis_tlast);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    if (m_axis_tdata !== e.d || m_axis_tlast !== e.l) begin
                        errors++;
                        $display("FAIL beat: got d=%h l=%b, need d=%h l=%b",
                                 m_axis_tdata, m_axis_tlast, e.d, e.l);
                    end
                end
            end
            if (frame_done) begin
                done_cnt++;
                checks++;
                if (exp_q.size() != 0 || m_axis_tvalid !== 1'b0) begin
                    errors++;
                    $display("FAIL done_early: got pending=%0d v=%b, need 0 and 0",
                             exp_q.size(), m_axis_tvalid);
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_d     = m_axis_tdata;
            prev_l     = m_axis_tlast;
        end
    end

    // Drive one pixel, wait for acceptance, update the model. Returns with
    // the clock 1 time unit past the accepting edge.
    task automatic send_pixel(input logic [PW-1:0] d, input bit user, input int gap, output bit en);
        int n;
        s_axis_tvalid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        s_axis_tdata  = d;
        s_axis_tuser  = user;
        s_axis_tvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (s_axis_tready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (s_axis_tready !== 1'b1) begin
            errors++;
            checks++;
            $display("FAIL accept_timeout: got s_ready=%b, need 1", s_axis_tready);
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        if (user) begin
            mr = 0;
            mc = 0;
        end
        mdl[mr][mc] = d;
        en = (mr >= 2 && mc >= 2);
        if (en) begin
            for (int k = 0; k < 9; k++) begin
                exp_q.push_back('{d: mdl[mr - 2 + k / 3][mc - 2 + k % 3], l: (k == 8)});
            end
            if (mr == H - 1 && mc == W - 1) exp_done++;
        end
        if (mc == W - 1) begin
            mc = 0;
            mr = (mr == H - 1) ? 0 : mr + 1;
        end else begin
            mc++;
        end
    endtask

    task automatic drive_frame(input logic [7:0] tag, input bit gaps);
        bit en;
        int gap;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                gap = (gaps && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3)) : 0;
                send_pixel({tag, 8'(r), 8'(c)}, 1'b0, gap, en);
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid === 1'b1) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL drain: got pending=%0d v=%b, need 0 and 0", exp_q.size(), m_axis_tvalid);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== '0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b l=%b d=%h fd=%b, need 0 0 000000 0",
                     m_axis_tvalid, m_axis_tlast, m_axis_tdata, frame_done);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got s_ready=%b v=%b, need 1 0", s_axis_tready, m_axis_tvalid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_done(input string name);
        checks++;
        if (done_cnt != exp_done) begin
            errors++;
            $display("FAIL %s_frame_done: got %0d pulses, need %0d", name, done_cnt, exp_done);
        end
    endtask

    task automatic test_full_frame();
        rdy_mode = 0;
        drive_frame(8'h00, 1'b0);
        drain();
        check_done("full_frame");
    endtask

    task automatic test_tready_toggle();
        rdy_mode = 1;
        drive_frame(8'h00, 1'b0);
        drain();
        rdy_mode = 0;
        check_done("toggle");
    endtask

    task automatic test_back_to_back();
        rdy_mode = 0;
        drive_frame(8'h00, 1'b0);
        drive_frame(8'h00, 1'b0);
        drain();
        check_done("back_to_back");
    endtask

    task automatic test_resync();
        bit en;
        int cnt;
        int first_at;
        rdy_mode = 0;
        // Five stray pixels, then start-of-frame on the sixth.
        for (int k = 0; k < 5; k++) begin
            send_pixel({8'hEE, 8'h00, 8'(k)}, 1'b0, 0, en);
        end
        cnt = 0;
        first_at = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                send_pixel({8'h00, 8'(r), 8'(c)}, (r == 0 && c == 0), 0, en);
                cnt++;
                if (en && first_at == 0) first_at = cnt;
                checks++;
                if (m_axis_tvalid !== en) begin
                    errors++;
                    $display("FAIL resync_valid(%0d,%0d): got %b, need %b", r, c, m_axis_tvalid, en);
                end
            end
        end
        checks++;
        if (first_at != 11) begin
            errors++;
            $display("FAIL resync_first_window: got pixel %0d, need 11", first_at);
        end
        drain();
        check_done("resync");
    endtask

    task automatic test_reset_mid();
        bit en;
        rdy_mode = 0;
        en = 1'b0;
        while (!en) begin
            send_pixel({8'h00, 8'(mr), 8'(mc)}, 1'b0, 0, en);
        end
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        checks++;
        if (exp_q.size() != 5) begin
            errors++;
            $display("FAIL pre_reset_beats: got %0d left, need 5", exp_q.size());
        end
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mr = 0;
        mc = 0;
        @(negedge clk);
        checks++;
        if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1 || m_axis_tlast !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got v=%b s_ready=%b l=%b, need 0 1 0",
                     m_axis_tvalid, s_axis_tready, m_axis_tlast);
        end
        @(posedge clk);
        #1;
        drive_frame(8'h00, 1'b0);
        drain();
        check_done("reset_mid");
    endtask

    task automatic test_gaps();
        rdy_mode = 0;
        drive_frame(8'h00, 1'b1);
        drive_frame(8'h00, 1'b1);
        drain();
        check_done("gaps");
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_tready_toggle();
        test_back_to_back();
        test_resync();
        test_reset_mid();
        test_gaps();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/window_streamer.md
Name: window_streamer

Overview:
- Raster-to-window front end for the 3x3 pixel filters.
- Accepts a raster-order RGB pixel stream, one pixel per beat, on an AXI-stream slave.
- Buffers the three most recent image rows and emits every interior 3x3 neighbourhood as a 9-beat AXI-stream packet on a master port.
- The master port feeds the filter's 9-pixel-per-result input directly.

Parameters:
- IMG_W, 64, image width in pixels (>=3)
- IMG_H, 64, image height in rows (>=3)
- PIX_W, 24, pixel width ({R,G,B}, 8 bits each)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- s_axis_tdata  in  PIX_W  raster pixel
- s_axis_tvalid  in  1  input pixel valid
- s_axis_tuser  in  1  start-of-frame; marks pixel (0,0)
- s_axis_tready  out  1  block can accept a pixel
- m_axis_tdata  out  PIX_W  window pixel
- m_axis_tvalid  out  1  window beat valid
- m_axis_tlast  out  1  9th beat of a window
- m_axis_tready  in  1  downstream accepts the beat
- frame_done  out  1  one-cycle pulse after the last window of a frame is accepted

Behaviour:
- Reset values: state=FILL, row=0, col=0, beat=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, frame_done=0. Reset is asynchronous and may assert at any cycle, including mid-window; the packet in flight is abandoned with no tlast.
- s_axis_tready is combinational, equal to (state==FILL). It is therefore 1 from the first cycle after reset.
- Storage is 3 rows x IMG_W x PIX_W, indexed by row mod 3 (circular). An accepted pixel (r,c) is written to slot [r mod 3][c].
- Position counters (row, col) advance on each accepted input beat:
  - col wraps at IMG_W-1 and increments row.
  - row wraps at IMG_H-1 back to 0 (start of the next frame).
- s_axis_tuser=1 on an accepted beat forces that pixel to position (0,0) regardless of the counters (resync). Subsequent counting continues from there.
- FSM states: FILL, SEND.
  - FILL -> SEND on acceptance of pixel (r,c) with r>=2 and c>=2.
    - The window centre is (r-1,c-1) and its base is (r-2,c-2), latched.
    - Next cycle: beat=0, m_axis_tvalid=1, m_axis_tdata=pixel(r-2,c-2).
  - SEND: beat k (0..8) carries pixel(base_r + k/3, base_c + k%3). Beat order is row-major, top-left first.
  - SEND: m_axis_tlast=1 only when beat==8.
  - SEND: on m_axis_tvalid && m_axis_tready the beat increments and the next pixel is registered for the following cycle. Data is back-to-back when tready is held high.
  - SEND: while m_axis_tready=0, tdata, tvalid and tlast are held stable; this is AXI-stream compliant.
  - SEND -> FILL when beat 8 is accepted; m_axis_tvalid and m_axis_tlast drop the next cycle.
  - If that window was the frame's last one (base row=IMG_H-3, base col=IMG_W-3), frame_done=1 for exactly one cycle, coincident with the return to FILL.
- Latency: first beat of a window is valid 1 cycle after the enabling input handshake.
- Throughput: minimum 10 cycles per interior pixel (1 fill + 9 send). Border input pixels (r<2 or c<2) are accepted back-to-back.
- No window is emitted for border centres. A frame yields (IMG_W-2)*(IMG_H-2) windows of 9 beats each.
- s_axis_tvalid gaps in FILL stall the block with no side effects. Input is never accepted in SEND.
- Row-buffer wrap: slot selection is always (row mod 3). No data from the previous frame appears in a window, because windows require r>=2 within the current frame.

Decomposition:
- Shared package dip_pkg holds:
  - PIX_W default
  - stream_state_e enum {FILL, SEND}
  - function win_offset(k) returning {k/3, k%3}
- One natural sub-module: row_store. It holds the 3-row circular buffer, with a write port (row slot, col, data) and a read port (row slot, col). The read port is combinational, registered by the parent.

Test Plan:
(All scenarios use IMG_W=4, IMG_H=4, and input data = {8'h00, row, col}.)
- Full frame, tready=1: 4 windows are emitted in order for centres (1,1), (1,2), (2,1), (2,2). Window 1 is 0x000000,0x000001,0x000002,0x000100,0x000101,0x000102,0x000200,0x000201,0x000202, with tlast only on the 9th beat. frame_done pulses once after window 4.
- m_axis_tready toggling 1010... during a window: each beat's tdata and tlast are held until accepted; s_axis_tready=0 throughout SEND; no beat is lost or duplicated.
- Two back-to-back frames (row counter wraps, row slots wrap mod 3): the second frame's windows equal the first frame's; frame_done pulses twice.
- s_axis_tuser=1 asserted on the 6th pixel of a frame: that pixel becomes (0,0), and the first window appears only after 11 further pixels, with base equal to the resynced (0,0).
- rst pulsed during beat 4 of a window: m_axis_tvalid=0 and s_axis_tready=1 the cycle after release; the next frame produces correct windows.
- Random s_axis_tvalid gaps (~50%): the window contents and order match the gap-free run exactly.
